reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Board-level reset controller. Combines the GSE reset, POR input, PLL lock and a
//  command-driven soft reset, then releases N_DOM reset domains in a fixed order.
//  Each domain is released STAGE_DLY cycles after the previous one. Records the cause
//  of the last reset and drives the per-domain rst_n inputs of downstream clock buffers.
// PARAMETERS
//  N_DOM      4      number of sequenced reset domains (2..8)
//  HOLD_CYC   1024   POR stretch, in clk50 cycles after synchronized por_n goes high
//  STAGE_DLY  16     cycles between consecutive domain releases (>=1)
//  SOFT_LEN   8      cycles all domains are held low for a soft reset (>=1)
//  LOCK_TMO   65535  PLL lock watchdog timeout in cycles (used only with the macro)
//  CNT_W      27     shared counter width; must hold max(HOLD_CYC, LOCK_TMO, STAGE_DLY)
// PORTS
//  clk50         in   1      50 MHz system clock
//  gse_resetn    in   1      asynchronous, active-low reset
//  por_n         in   1      POR, active low, asynchronous to clk50 (2-FF synchronized)
//  pll_lock      in   1      PLL lock, asynchronous to clk50 (2-FF synchronized)
//  soft_rst_req  in   1      1-cycle soft reset request pulse, synchronous to clk50
//  rst_n_out     out  N_DOM  domain resets, active low; bit 0 is released first
//  seq_done      out  1      1 = all domains released (state RUN)
//  rst_cause     out  2      00 GSE, 01 POR, 10 SOFT, 11 LOCK loss; sticky
//  lock_fault    out  1      watchdog expired before lock; sticky until gse_resetn
// BEHAVIOUR
//  Reset (gse_resetn=0): state=HOLD, cnt=0, idx=0, rst_n_out=0, seq_done=0,
//   rst_cause=00, lock_fault=0, sync flops=0.
//  All outputs are registered. por_s and lock_s are the synchronized por_n and pll_lock.
//  HOLD: rst_n_out=0. While por_s=0, cnt=0. Otherwise cnt increments each cycle.
//   When cnt reaches HOLD_CYC-1: cnt=0, go to WAIT_LOCK.
//  WAIT_LOCK: rst_n_out=0. When lock_s=1: cnt=0, idx=0, go to RELEASE.
//  RELEASE: cnt counts 0..STAGE_DLY-1. On the wrap, rst_n_out[idx]<=1 and idx++.
//   Bit k goes high (k+1)*STAGE_DLY cycles after RELEASE is entered.
//   Released bits stay high. The cycle bit N_DOM-1 is released: go to RUN, seq_done<=1.
//  RUN: steady state; rst_n_out all ones, seq_done=1.
//  SOFT: rst_n_out=0, seq_done=0. After SOFT_LEN cycles, go to WAIT_LOCK.
//  Abort events (priority high->low; evaluated every cycle):
//   1) por_s=0 in any state except HOLD: next cycle rst_n_out=0, seq_done=0,
//      rst_cause=01, state HOLD.
//   2) lock_s=0 in RELEASE or RUN: next cycle rst_n_out=0, seq_done=0,
//      rst_cause=11, state WAIT_LOCK.
//   3) soft_rst_req=1 in RELEASE or RUN: next cycle rst_n_out=0, seq_done=0,
//      rst_cause=10, state SOFT.
//  soft_rst_req in HOLD, WAIT_LOCK or SOFT is ignored; it is not queued.
//  Simultaneous events: only the highest-priority event applies; rst_cause records that one.
//  Counter: cnt clears on every state entry; no wrap beyond the terminal count.
//  idx width is clog2(N_DOM).
// CONFIGURATION
//  RST_SEQ_LOCK_WDOG_EN defined:
//   - In WAIT_LOCK, cnt counts while lock_s=0.
//   - At cnt==LOCK_TMO-1: lock_fault<=1, go to RELEASE (sequence proceeds unlocked).
//   - Rule 2 is then suppressed until lock_s next goes 1.
//  RST_SEQ_LOCK_WDOG_EN undefined:
//   - WAIT_LOCK waits indefinitely for lock.
//   - lock_fault is tied to 0.
// TESTING  (N_DOM=4, HOLD_CYC=16, STAGE_DLY=4, SOFT_LEN=8, LOCK_TMO=100)
//  1 gse_resetn 0->1, por_n=1, pll_lock=1 ->
//    bits 0..3 go high 4, 8, 12, 16 cycles after RELEASE entry; seq_done rises with bit3;
//    rst_cause=00.
//  2 RUN, por_n=0 for 100 ns ->
//    rst_n_out=0 within 3 clocks; rst_cause=01;
//    full resequence with 16-cycle hold after por_n returns.
//  3 RUN, soft_rst_req 1-cycle pulse ->
//    rst_n_out=0 next cycle; held 8 cycles; WAIT_LOCK then resequence; rst_cause=10.
//  4 RELEASE with bit0 high, pll_lock=0 ->
//    rst_n_out=0 by sync+1 cycles; rst_cause=11; stays in WAIT_LOCK;
//    restarts at bit0 when lock returns.
//  5 por_n=0 and soft_rst_req=1 reaching the FSM in the same cycle ->
//    rst_cause=01, state HOLD.
//  6 pll_lock held 0:
//    with macro: lock_fault=1 after 100 cycles in WAIT_LOCK, then domains release;
//    without macro: rst_n_out stays 0 for 10000 cycles and lock_fault=0.

Source files
------------

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - board reset controller releasing N_DOM domains in order
// Optional PLL lock watchdog enabled by defining RST_SEQ_LOCK_WDOG_EN.
module reset_sequencer #(
    parameter int N_DOM     = 4,
    parameter int HOLD_CYC  = 1024,
    parameter int STAGE_DLY = 16,
    parameter int SOFT_LEN  = 8,
    parameter int LOCK_TMO  = 65535,
    parameter int CNT_W     = 27
) (
    input  logic             clk50,
    input  logic             gse_resetn,
    input  logic             por_n,
    input  logic             pll_lock,
    input  logic             soft_rst_req,
    output logic [N_DOM-1:0] rst_n_out,
    output logic             seq_done,
    output logic [1:0]       rst_cause,
    output logic             lock_fault
);

    localparam int IDX_W = $clog2(N_DOM);

    localparam logic [2:0] ST_HOLD      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_SOFT      = 3'd4;

    localparam logic [1:0] CAUSE_GSE  = 2'b00;
    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;
    localparam logic [1:0] CAUSE_LOCK = 2'b11;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_LEN - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TMO - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DOM - 1);

`ifdef RST_SEQ_LOCK_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    logic             por_meta_q, por_s_q;
    logic             lock_meta_q, lock_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_DOM-1:0] rst_n_q, rst_n_d;
    logic             done_q, done_d;
    logic [1:0]       cause_q, cause_d;
    logic             fault_q, fault_d;
    logic             byp_q, byp_d;
    logic             running;
    logic             lock_abort;

    assign running    = (state_q == ST_RELEASE) || (state_q == ST_RUN);
    // After a watchdog timeout the sequence runs unlocked, so lock loss is ignored until lock is seen
    assign lock_abort = !lock_s_q && !byp_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        done_d  = done_q;
        cause_d = cause_q;
        fault_d = fault_q;
        byp_d   = byp_q;
        if (lock_s_q) begin
            byp_d = 1'b0;
        end
        if ((state_q != ST_HOLD) && !por_s_q) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
            cause_d = CAUSE_POR;
        end else if (running && lock_abort) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
            cause_d = CAUSE_LOCK;
        end else if (running && soft_rst_req) begin
            state_d = ST_SOFT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
            cause_d = CAUSE_SOFT;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (!por_s_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = ST_RELEASE;
                    end else if (WDOG_EN) begin
                        if (cnt_q == LOCK_LAST) begin
                            cnt_d   = '0;
                            idx_d   = '0;
                            fault_d = 1'b1;
                            byp_d   = 1'b1;
                            state_d = ST_RELEASE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STAGE_LAST) begin
                        cnt_d          = '0;
                        rst_n_d[idx_q] = 1'b1;
                        idx_d          = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                ST_SOFT: begin
                    if (cnt_q == SOFT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_n_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk50 or negedge gse_resetn) begin
        if (!gse_resetn) begin
            por_meta_q  <= 1'b0;
            por_s_q     <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_n_q     <= '0;
            done_q      <= 1'b0;
            cause_q     <= CAUSE_GSE;
            fault_q     <= 1'b0;
            byp_q       <= 1'b0;
        end else begin
            por_meta_q  <= por_n;
            por_s_q     <= por_meta_q;
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rst_n_q     <= rst_n_d;
            done_q      <= done_d;
            cause_q     <= cause_d;
            fault_q     <= fault_d;
            byp_q       <= byp_d;
        end
    end

    assign rst_n_out  = rst_n_q;
    assign seq_done   = done_q;
    assign rst_cause  = cause_q;
    assign lock_fault = fault_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    localparam int N_DOM     = 4;
    localparam int HOLD_CYC  = 16;
    localparam int STAGE_DLY = 4;
    localparam int SOFT_LEN  = 8;
    localparam int LOCK_TMO  = 100;
    localparam int CNT_W     = 27;

    logic             clk50 = 1'b0;
    logic             gse_resetn;
    logic             por_n;
    logic             pll_lock;
    logic             soft_rst_req;
    logic [N_DOM-1:0] rst_n_out;
    logic             seq_done;
    logic [1:0]       rst_cause;
    logic             lock_fault;

    int n_vec  = 0;
    int n_err  = 0;
    int tcount = 0;

    reset_sequencer #(
        .N_DOM    (N_DOM),
        .HOLD_CYC (HOLD_CYC),
        .STAGE_DLY(STAGE_DLY),
        .SOFT_LEN (SOFT_LEN),
        .LOCK_TMO (LOCK_TMO),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk50       (clk50),
        .gse_resetn  (gse_resetn),
        .por_n       (por_n),
        .pll_lock    (pll_lock),
        .soft_rst_req(soft_rst_req),
        .rst_n_out   (rst_n_out),
        .seq_done    (seq_done),
        .rst_cause   (rst_cause),
        .lock_fault  (lock_fault)
    );

    always #10 clk50 = ~clk50;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
        tcount++;
    endtask

    // t0 is the tick (counted from tcount=0) at which bit 0 is expected to rise
    task automatic check_release(input int t0, input string tag);
        while (tcount < t0 + 3 * STAGE_DLY) begin
            tick();
            if (tcount == t0 - 1)
                check_vec({tag, "_pre"}, 32'(rst_n_out), 32'h0);
            for (int k = 0; k < N_DOM; k++) begin
                if (tcount == t0 + k * STAGE_DLY)
                    check_vec($sformatf("%s_bit%0d", tag, k), 32'(rst_n_out), (32'h1 << (k + 1)) - 32'h1);
            end
            if (tcount == t0 + 3 * STAGE_DLY - 1)
                check_vec({tag, "_done_early"}, 32'(seq_done), 32'h0);
        end
        check_vec({tag, "_done"}, 32'(seq_done), 32'h1);
    endtask

    initial begin
        gse_resetn   = 1'b0;
        por_n        = 1'b1;
        pll_lock     = 1'b1;
        soft_rst_req = 1'b0;
        repeat (3) tick();
        check_vec("rst_rst_n", 32'(rst_n_out), 32'h0);
        check_vec("rst_done", 32'(seq_done), 32'h0);
        check_vec("rst_cause", 32'(rst_cause), 32'h0);
        check_vec("rst_fault", 32'(lock_fault), 32'h0);

        // 1: power-up sequence, 2 sync + 16 hold + 1 wait + 4 stage
        gse_resetn = 1'b1;
        tcount = 0;
        check_release(23, "t1");
        check_vec("t1_cause", 32'(rst_cause), 32'h0);

        // 2: POR pulse in RUN
        repeat (5) tick();
        tcount = 0;
        por_n = 1'b0;
        tick();
        tick();
        check_vec("t2_still_run", 32'(rst_n_out), 32'hF);
        tick();
        check_vec("t2_rst_n", 32'(rst_n_out), 32'h0);
        check_vec("t2_done", 32'(seq_done), 32'h0);
        check_vec("t2_cause", 32'(rst_cause), 32'h1);
        tick();
        tick();
        por_n = 1'b1;
        tcount = 0;
        check_release(23, "t2");
        check_vec("t2_cause_sticky", 32'(rst_cause), 32'h1);

        // 3: soft reset, with a second pulse during SOFT that must be ignored
        tcount = 0;
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check_vec("t3_rst_n", 32'(rst_n_out), 32'h0);
        check_vec("t3_done", 32'(seq_done), 32'h0);
        check_vec("t3_cause", 32'(rst_cause), 32'h2);
        tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check_vec("t3_held", 32'(rst_n_out), 32'h0);
        check_release(14, "t3");

        // 4: lock loss during RELEASE after bit 0
        tcount = 0;
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        while (tcount < 14) tick();
        check_vec("t4_bit0", 32'(rst_n_out), 32'h1);
        pll_lock = 1'b0;
        tick();
        tick();
        check_vec("t4_before", 32'(rst_n_out), 32'h1);
        tick();
        check_vec("t4_rst_n", 32'(rst_n_out), 32'h0);
        check_vec("t4_cause", 32'(rst_cause), 32'h3);
        repeat (20) tick();
        check_vec("t4_wait", 32'(rst_n_out), 32'h0);
        check_vec("t4_wait_done", 32'(seq_done), 32'h0);
        pll_lock = 1'b1;
        tcount = 0;
        check_release(7, "t4");
        check_vec("t4_cause_sticky", 32'(rst_cause), 32'h3);

        // 5: POR and soft request reach the FSM in the same cycle
        repeat (3) tick();
        tcount = 0;
        por_n = 1'b0;
        tick();
        tick();
        check_vec("t5_still_run", 32'(rst_n_out), 32'hF);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check_vec("t5_rst_n", 32'(rst_n_out), 32'h0);
        check_vec("t5_cause", 32'(rst_cause), 32'h1);
        tick();
        tick();
        por_n = 1'b1;
        tcount = 0;
        check_release(23, "t5");
        check_vec("t5_cause_sticky", 32'(rst_cause), 32'h1);

        // 6: PLL never locks
        gse_resetn = 1'b0;
        pll_lock   = 1'b0;
        tick();
        tick();
        check_vec("t6_rst_cause", 32'(rst_cause), 32'h0);
        check_vec("t6_rst_rst_n", 32'(rst_n_out), 32'h0);
        gse_resetn = 1'b1;
        tcount = 0;
`ifdef RST_SEQ_LOCK_WDOG_EN
        while (tcount < 117) tick();
        check_vec("t6_fault_early", 32'(lock_fault), 32'h0);
        check_vec("t6_rst_n_early", 32'(rst_n_out), 32'h0);
        tick();
        check_vec("t6_fault", 32'(lock_fault), 32'h1);
        check_release(122, "t6");
        check_vec("t6_fault_sticky", 32'(lock_fault), 32'h1);
        check_vec("t6_cause", 32'(rst_cause), 32'h0);
`else
        while (tcount < 10000) begin
            tick();
            if (tcount % 2000 == 0)
                check_vec($sformatf("t6_rst_n_%0d", tcount), 32'(rst_n_out), 32'h0);
        end
        check_vec("t6_fault", 32'(lock_fault), 32'h0);
        check_vec("t6_done", 32'(seq_done), 32'h0);
        check_vec("t6_cause", 32'(rst_cause), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
